pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised pipeline stage register that generalises the fixed ID/EX-style latch into an elastic stage. It has a configurable payload width and a DEPTH-entry in-order skid buffer with valid/ready handshakes on both sides. It supports flush-to-bubble and a sideband field that advances every cycle regardless of stalls. It sits between any two stages of the riscv_pipelined core; control bundles are packed into the payload by the instantiating stage.

## Interface
- DATA_W, 128, payload width in bits (≥1)
- SIDE_W, 1, sideband width in bits (≥1); the sideband is never stalled
- DEPTH, 2, buffer entries (1..4); 1 gives at most 50% throughput, ≥2 gives 1 transfer/cycle
- BUBBLE, '0, DATA_W-bit payload presented on out_data when the stage is empty
- Reset: rst is synchronous and active-low. Clock: clk.
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-low reset
- in_valid  in  1  upstream has a payload
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready
- in_data  in  DATA_W  upstream payload
- in_side  in  SIDE_W  sideband input
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- out_data  out  DATA_W  head payload, or BUBBLE when empty
- out_side  out  SIDE_W  in_side delayed one cycle
- flush  in  1  discard all buffered entries
- count  out  $clog2(DEPTH+1)  occupancy

## Operation
- Push occurs when in_valid && in_ready.
- Pop occurs when out_valid && out_ready.
- Storage is a circular buffer with read and write pointers. Pointers wrap from DEPTH-1 to 0, including when DEPTH is not a power of two.
- count next value = count + push − pop.
- in_ready next value = (count next value < DEPTH).
- out_valid = (count ≠ 0).
- out_data = mem[rd_ptr] when out_valid is 1; otherwise out_data = BUBBLE exactly.
- Entries leave in strict FIFO order. No entry is duplicated or dropped except by flush.
- Simultaneous push and pop:
  - count is unchanged and both pointers advance.
  - If the buffer is empty, pop cannot occur (out_valid=0), so only the push takes effect.
- When full, in_ready=0, so no push occurs. A pop in that cycle raises in_ready on the next cycle.
- Flush:
  - All entries are dropped.
  - Next cycle: count=0, pointers=0, out_valid=0, out_data=BUBBLE, in_ready=1.
  - A push presented in the flush cycle is discarded (flush wins).
  - A pop in the flush cycle still counts as consumed by downstream.
- Sideband: out_side <= in_side every cycle, independent of push, pop, stall, full or flush.
- Reset (rst=0 at posedge) forces:
  - count=0, pointers=0, out_valid=0, out_data=BUBBLE, in_ready=1, out_side=0.
  - in_valid, out_ready and flush are ignored in that cycle.
  - Reset mid-operation discards all contents. Reset has priority over flush.
- Payload memory contents need not be cleared; only pointers and count are reset.

## Timing
- Latency: a push at edge N presents the payload on out_data with out_valid=1 after edge N (cycle N+1) when the stage was empty. No same-cycle bypass.
- Throughput: with DEPTH≥2, one transfer per cycle is sustained under continuous in_valid and out_ready. With DEPTH=1, at most one transfer per 2 cycles.
- in_ready, out_valid, count and out_side are pure register outputs.
- out_data is a registered-memory mux, with no input-to-output combinational path.
- Backpressure: holding out_ready=0 leaves out_data and out_valid stable until a pop or flush.
- Sideband: one cycle of latency always.

## Test plan
- Reset:
  - Stimulus: assert rst=0 for 2 cycles with in_valid=1 and in_data=0xAA.
  - Required response: count=0, out_valid=0, out_data=BUBBLE, in_ready=1, out_side=0 after release; nothing is enqueued.
- Streaming, DEPTH=2, out_ready=1:
  - Stimulus: push 0x1..0x8 on consecutive cycles.
  - Required response: out_data shows 0x1..0x8 on consecutive cycles starting one cycle later; count never exceeds 1; in_ready stays 1.
- Fill and backpressure, DEPTH=3:
  - Stimulus: hold out_ready=0 and push 0x10, 0x11, 0x12.
  - Required response: in_ready=0 and count=3; a 4th push of 0x13 is refused; out_data holds 0x10.
  - Stimulus: release out_ready.
  - Required response: 0x10, 0x11, 0x12, 0x13 drain in order; pointer wrap is exercised.
- Flush:
  - Stimulus: with count=2, assert flush together with a push of 0x55.
  - Required response: next cycle count=0, out_valid=0, out_data=BUBBLE; 0x55 never appears on out_data.
- Sideband under stall:
  - Stimulus: with out_ready=0 and the stage full, toggle in_side 0,1,0,1.
  - Required response: out_side follows with exactly 1-cycle delay.
  - Stimulus: apply flush.
  - Required response: out_side is unaffected.
- Random traffic, DEPTH ∈ {1,3,4}:
  - Stimulus: 10k cycles of random in_valid, out_ready and 1% flush.
  - Required response: a scoreboard matches FIFO order; count stays within 0..DEPTH; DEPTH=1 never accepts a push in the same cycle as a pop from full.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH-entry in-order skid buffer with valid/ready on both
// sides, flush-to-bubble, and a sideband field that advances every cycle.
module pipe_stage_buf #(
    parameter int                 DATA_W = 128,
    parameter int                 SIDE_W = 1,
    parameter int                 DEPTH  = 2,
    parameter logic [DATA_W-1:0]  BUBBLE = '0,
    localparam int                CNT_W  = $clog2(DEPTH + 1),
    localparam int                PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [SIDE_W-1:0] out_side_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              push_s;
    logic              pop_s;

    // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    assign push_s = in_valid && in_ready_q;
    assign pop_s  = out_valid_q && out_ready;

    // Next-state for pointers, occupancy and the registered handshake flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
        in_ready_d  = (count_d < CNT_W'(DEPTH));
        out_valid_d = (count_d != {CNT_W{1'b0}});
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_side_q  <= {SIDE_W{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_side_q  <= in_side;
        end
    end

    // Payload storage; contents are never cleared, only pointers are.
    always_ff @(posedge clk) begin
        if (rst && push_s && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign out_side  = out_side_q;
    assign out_data  = out_valid_q ? mem_q[rd_ptr_q] : BUBBLE;

endmodule
